// File: rtl/hlsm_job_arbiter_if.sv
// hlsm_job_arbiter_if: client request/result and HLSM Start/Done signals of the job arbiter
interface hlsm_job_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int OPW     = 72,
  parameter int RESW    = 8
);
  logic [NUM_REQ-1:0]     Req;
  logic [NUM_REQ*OPW-1:0] OpIn;
  logic [NUM_REQ-1:0]     Ack;
  logic [RESW-1:0]        Result;
  logic                   Err;
  logic                   Busy;
  logic [2:0]             GrantId;
  logic                   HlsStart;
  logic [OPW-1:0]         HlsOps;
  logic                   HlsDone;
  logic [RESW-1:0]        HlsResult;
  modport master (
    output Req, OpIn, HlsDone, HlsResult,
    input  Ack, Result, Err, Busy, GrantId, HlsStart, HlsOps
  );
  modport slave (
    input  Req, OpIn, HlsDone, HlsResult,
    output Ack, Result, Err, Busy, GrantId, HlsStart, HlsOps
  );
endinterface

// File: rtl/hlsm_job_arbiter.sv
// hlsm_job_arbiter: round-robin sharing of one HLSM datapath between NUM_REQ requesters.
// Define HLSM_ARB_TIMEOUT_EN to add a WAIT watchdog that completes the job with Err=1.
module hlsm_job_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int OPW            = 72,
  parameter int RESW           = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic Clk,
  input logic Rst,
  hlsm_job_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("hlsm_job_arbiter: parameter out of range");
  end

  state_t             state_q;
  logic [2:0]         rr_q;
  logic [2:0]         grant_q;
  logic [NUM_REQ-1:0] ack_q;
  logic [RESW-1:0]    result_q;
  logic               start_q;
  logic [OPW-1:0]     ops_q;
  logic [2:0]         win_d;
  int                 k;

  // Scan offsets from the highest down so the nearest set bit above rr_q is the last to win.
  always_comb begin
    win_d = rr_q;
    k = 0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      k = (int'(rr_q) + j) % NUM_REQ;
      if (bus.Req[k]) win_d = 3'(k);
    end
  end

`ifdef HLSM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_q;
  logic          err_q;
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      grant_q  <= '0;
      ack_q    <= '0;
      result_q <= '0;
      start_q  <= 1'b0;
      ops_q    <= '0;
      tmo_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (|bus.Req) begin
          grant_q <= win_d;
          ops_q   <= bus.OpIn[int'(win_d)*OPW +: OPW];
          start_q <= 1'b1;
          state_q <= START;
        end
        START: begin
          start_q <= 1'b0;
          tmo_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: if (bus.HlsDone) begin
          ack_q    <= NUM_REQ'(1) << grant_q;
          result_q <= bus.HlsResult;
          err_q    <= 1'b0;
          state_q  <= RESP;
        end else if (tmo_q == CW'(TIMEOUT_CYCLES - 1)) begin
          ack_q    <= NUM_REQ'(1) << grant_q;
          result_q <= '0;
          err_q    <= 1'b1;
          state_q  <= RESP;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
        default: begin
          ack_q    <= '0;
          result_q <= '0;
          err_q    <= 1'b0;
          rr_q     <= (grant_q == 3'(NUM_REQ - 1)) ? 3'd0 : grant_q + 3'd1;
          state_q  <= IDLE;
        end
      endcase
    end
  end
  assign bus.Err = err_q;
`else
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      grant_q  <= '0;
      ack_q    <= '0;
      result_q <= '0;
      start_q  <= 1'b0;
      ops_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (|bus.Req) begin
          grant_q <= win_d;
          ops_q   <= bus.OpIn[int'(win_d)*OPW +: OPW];
          start_q <= 1'b1;
          state_q <= START;
        end
        START: begin
          start_q <= 1'b0;
          state_q <= WAIT;
        end
        WAIT: if (bus.HlsDone) begin
          ack_q    <= NUM_REQ'(1) << grant_q;
          result_q <= bus.HlsResult;
          state_q  <= RESP;
        end
        default: begin
          ack_q    <= '0;
          result_q <= '0;
          rr_q     <= (grant_q == 3'(NUM_REQ - 1)) ? 3'd0 : grant_q + 3'd1;
          state_q  <= IDLE;
        end
      endcase
    end
  end
  assign bus.Err = 1'b0;
`endif

  assign bus.Ack      = ack_q;
  assign bus.Result   = result_q;
  assign bus.Busy     = state_q != IDLE;
  assign bus.GrantId  = grant_q;
  assign bus.HlsStart = start_q;
  assign bus.HlsOps   = ops_q;
endmodule
